// File: rtl/delay_tap_ctrl.sv
// Tap controller for a VAR_LOAD-style delay element: drops EN_VTC, walks the tap to the
// requested value one step at a time, verifies it, and restores EN_VTC. Optional macro:
// DLY_TAP_LOAD_MODE_EN makes the first step of each request a direct CNTVALUEIN load.
module delay_tap_ctrl #(
  parameter int VTC_WAIT      = 8,
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_STEPS     = 511
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ_VALID,
  input  logic [8:0] REQ_TAP,
  output logic       REQ_READY,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  output logic       DLY_CE,
  output logic       DLY_INC,
  output logic       DLY_LOAD,
  output logic [8:0] DLY_CNTVALUEIN,
  output logic       DLY_EN_VTC,
  input  logic [8:0] DLY_CNTVALUEOUT
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] VTC_OFF = 3'd1;
  localparam logic [2:0] STEP    = 3'd2;
  localparam logic [2:0] SETTLE  = 3'd3;
  localparam logic [2:0] CHECK   = 3'd4;
  localparam logic [2:0] VTC_ON  = 3'd5;

  localparam int CNT_W = (MAX_STEPS < 2) ? 1 : $clog2(MAX_STEPS + 1);

  logic [2:0]       state_q, state_d;
  logic [7:0]       timer_q, timer_d;
  logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
  logic [8:0]       target_q, target_d;
  logic             ok_q, ok_d;
  logic             go_step;

  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             ce_q, ce_d;
  logic             inc_q, inc_d;
  logic             load_q, load_d;
  logic [8:0]       cntin_q, cntin_d;
  logic             en_vtc_q, en_vtc_d;

`ifdef DLY_TAP_LOAD_MODE_EN
  logic             first_q, first_d;
`endif

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    step_cnt_d = step_cnt_q;
    target_d   = target_q;
    ok_d       = ok_q;
    go_step    = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    ce_d       = 1'b0;
    inc_d      = 1'b0;
    load_d     = 1'b0;
    cntin_d    = '0;
`ifdef DLY_TAP_LOAD_MODE_EN
    first_d    = first_q;
`endif

    case (state_q)
      IDLE: begin
        if (REQ_VALID && ready_q) begin
          target_d = REQ_TAP;
          // Already on target: answer immediately without touching EN_VTC
          if (REQ_TAP == DLY_CNTVALUEOUT) begin
            done_d = 1'b1;
          end else begin
            state_d    = VTC_OFF;
            timer_d    = 8'(VTC_WAIT - 1);
            step_cnt_d = '0;
`ifdef DLY_TAP_LOAD_MODE_EN
            first_d    = 1'b1;
`endif
          end
        end
      end
      VTC_OFF: begin
        if (timer_q == 8'd0) go_step = 1'b1;
        else                 timer_d = timer_q - 8'd1;
      end
      STEP: begin
        if (SETTLE_CYCLES == 0) begin
          state_d = CHECK;
        end else begin
          state_d = SETTLE;
          timer_d = 8'(SETTLE_CYCLES - 1);
        end
      end
      SETTLE: begin
        if (timer_q == 8'd0) state_d = CHECK;
        else                 timer_d = timer_q - 8'd1;
      end
      CHECK: begin
        if (DLY_CNTVALUEOUT == target_q) begin
          state_d = VTC_ON;
          ok_d    = 1'b1;
          timer_d = 8'(VTC_WAIT - 1);
        end else if (step_cnt_q == CNT_W'(MAX_STEPS)) begin
          state_d = VTC_ON;
          ok_d    = 1'b0;
          timer_d = 8'(VTC_WAIT - 1);
        end else begin
          go_step = 1'b1;
        end
      end
      VTC_ON: begin
        if (timer_q == 8'd0) begin
          state_d = IDLE;
          done_d  = ok_q;
          err_d   = ~ok_q;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Direction is recomputed on every step so an overshoot walks back instead of wrapping
    if (go_step) begin
      state_d    = STEP;
      step_cnt_d = step_cnt_q + CNT_W'(1);
      ce_d       = 1'b1;
`ifdef DLY_TAP_LOAD_MODE_EN
      first_d    = 1'b0;
      if (first_q) begin
        load_d  = 1'b1;
        cntin_d = target_q;
      end else begin
        inc_d = (target_q > DLY_CNTVALUEOUT);
      end
`else
      inc_d      = (target_q > DLY_CNTVALUEOUT);
`endif
    end

    ready_d  = (state_d == IDLE);
    busy_d   = (state_d != IDLE);
    en_vtc_d = !(state_d inside {VTC_OFF, STEP, SETTLE, CHECK});
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      step_cnt_q <= '0;
      ok_q       <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ce_q       <= 1'b0;
      inc_q      <= 1'b0;
      load_q     <= 1'b0;
      cntin_q    <= '0;
      en_vtc_q   <= 1'b1;
`ifdef DLY_TAP_LOAD_MODE_EN
      first_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      step_cnt_q <= step_cnt_d;
      ok_q       <= ok_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ce_q       <= ce_d;
      inc_q      <= inc_d;
      load_q     <= load_d;
      cntin_q    <= cntin_d;
      en_vtc_q   <= en_vtc_d;
`ifdef DLY_TAP_LOAD_MODE_EN
      first_q    <= first_d;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    target_q <= target_d;
  end

  assign REQ_READY      = ready_q;
  assign BUSY           = busy_q;
  assign DONE           = done_q;
  assign ERR            = err_q;
  assign DLY_CE         = ce_q;
  assign DLY_INC        = inc_q;
  assign DLY_LOAD       = load_q;
  assign DLY_CNTVALUEIN = cntin_q;
  assign DLY_EN_VTC     = en_vtc_q;

endmodule

// File: tb/tb_delay_tap_ctrl.sv
// Bench for delay_tap_ctrl with a behavioural VAR_LOAD delay element whose tap
// follows CE one cycle later; directed table, reset/frozen corners and random requests.
module tb_delay_tap_ctrl;

  localparam int VW  = 4;
  localparam int SC  = 2;
  localparam int MXS = 511;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       REQ_VALID = 1'b0;
  logic [8:0] REQ_TAP = '0;
  logic       REQ_READY, BUSY, DONE, ERR;
  logic       DLY_CE, DLY_INC, DLY_LOAD, DLY_EN_VTC;
  logic [8:0] DLY_CNTVALUEIN;
  logic [8:0] DLY_CNTVALUEOUT;

  delay_tap_ctrl #(.VTC_WAIT(VW), .SETTLE_CYCLES(SC), .MAX_STEPS(MXS)) dut (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_TAP(REQ_TAP),
    .REQ_READY(REQ_READY), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .DLY_CE(DLY_CE), .DLY_INC(DLY_INC), .DLY_LOAD(DLY_LOAD),
    .DLY_CNTVALUEIN(DLY_CNTVALUEIN), .DLY_EN_VTC(DLY_EN_VTC),
    .DLY_CNTVALUEOUT(DLY_CNTVALUEOUT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Delay element model
  logic [8:0] tap = '0;
  logic       frozen = 1'b0;
  logic       preset_en = 1'b0;
  logic [8:0] preset_val = '0;
  always @(posedge CLK) begin
    if (preset_en) tap <= preset_val;
    else if (DLY_CE && !frozen) begin
      if (DLY_LOAD)     tap <= DLY_CNTVALUEIN;
      else if (DLY_INC) tap <= tap + 9'd1;
      else              tap <= tap - 9'd1;
    end
  end
  assign DLY_CNTVALUEOUT = tap;

  // Activity monitor
  int ce_cnt = 0, inc_cnt = 0, load_cnt = 0, vlow_cnt = 0, done_cnt = 0, err_cnt = 0;
  int viol_ce = 0, viol_vtc = 0, viol_de = 0, last_cntin = 0;
  logic prev_ce = 1'b0;
  always @(negedge CLK) begin
    if (DLY_CE) ce_cnt <= ce_cnt + 1;
    if (DLY_CE && DLY_INC) inc_cnt <= inc_cnt + 1;
    if (DLY_CE && DLY_LOAD) begin
      load_cnt   <= load_cnt + 1;
      last_cntin <= int'(DLY_CNTVALUEIN);
    end
    if (!DLY_EN_VTC) vlow_cnt <= vlow_cnt + 1;
    if (DONE) done_cnt <= done_cnt + 1;
    if (ERR) err_cnt <= err_cnt + 1;
    if (DLY_CE && prev_ce) viol_ce <= viol_ce + 1;
    if (DLY_CE && DLY_EN_VTC) viol_vtc <= viol_vtc + 1;
    if (DONE && ERR) viol_de <= viol_de + 1;
    prev_ce <= DLY_CE;
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // Reference: outcome of a request computed from start/target distance
  task automatic predict(input int s, input int t, input int fz, output int n, output int lat,
                         output int d, output int e, output int fin, output int ninc,
                         output int vlow);
    if (s == t) begin
      n = 0; lat = 1; d = 1; e = 0; fin = s; ninc = 0; vlow = 0;
    end else begin
`ifdef DLY_TAP_LOAD_MODE_EN
      if (fz != 0) begin
        n = MXS; d = 0; e = 1; fin = s; ninc = (t > s) ? MXS - 1 : 0;
      end else begin
        n = 1; d = 1; e = 0; fin = t; ninc = 0;
      end
`else
      if (fz != 0) begin
        n = MXS; d = 0; e = 1; fin = s; ninc = (t > s) ? MXS : 0;
      end else begin
        n = (t > s) ? t - s : s - t; d = 1; e = 0; fin = t; ninc = (t > s) ? n : 0;
      end
`endif
      vlow = VW + n * (SC + 2);
      lat  = vlow + VW + 1;
    end
  endtask

  task automatic preset(input int start);
    @(negedge CLK); preset_en = 1'b1; preset_val = 9'(start);
    @(negedge CLK); preset_en = 1'b0;
  endtask

  task automatic run_req(input int start, input int tgt, output int lat, output int d,
                         output int e, output int nce, output int ninc, output int nvlow,
                         output int after, output int tmo);
    int c0, i0, v0, a, k;
    preset(start);
    c0 = ce_cnt; i0 = inc_cnt; v0 = vlow_cnt; tmo = 0;
    k = 0;
    while (!REQ_READY && k < 100) begin @(negedge CLK); k++; end
    REQ_VALID = 1'b1; REQ_TAP = 9'(tgt);
    @(negedge CLK); a = cyc; REQ_VALID = 1'b0;
    k = 0;
    while (!(DONE || ERR) && k < 6000) begin @(negedge CLK); k++; end
    if (!(DONE || ERR)) tmo = 1;
    lat = cyc - a + 1; d = int'(DONE); e = int'(ERR);
    nce = ce_cnt - c0; ninc = inc_cnt - i0; nvlow = vlow_cnt - v0;
    @(negedge CLK); after = int'(DONE || ERR);
  endtask

  typedef struct {
    int start; int tgt; int exp_lat; int exp_ce; int exp_inc; int exp_tap; int exp_vlow;
  } vec_t;

  initial begin
    int lat, d, e, nce, ninc, nvlow, after, tmo;
    int pn, plat, pd, pe, pfin, pinc, pvlow;
    int a, dc0, ec0;
    string nm;
`ifndef DLY_TAP_LOAD_MODE_EN
    vec_t tbl[5];
    tbl[0] = '{0,   3,   21, 3, 3, 3,   16};
    tbl[1] = '{10,  7,   21, 3, 0, 7,   16};
    tbl[2] = '{100, 100, 1,  0, 0, 100, 0};
    tbl[3] = '{0,   1,   13, 1, 1, 1,   8};
    tbl[4] = '{511, 509, 17, 2, 0, 509, 12};
`endif

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_ready", REQ_READY, 0);
    check("rst_busy", BUSY, 0);
    check("rst_done_err", {30'd0, DONE, ERR}, 0);
    check("rst_ce_inc_load", {29'd0, DLY_CE, DLY_INC, DLY_LOAD}, 0);
    check("rst_cntin", DLY_CNTVALUEIN, 0);
    check("rst_en_vtc", DLY_EN_VTC, 1);
    RST = 1'b0;
    @(negedge CLK);
    check("ready_after_rst", REQ_READY, 1);

`ifndef DLY_TAP_LOAD_MODE_EN
    for (int i = 0; i < 5; i++) begin
      run_req(tbl[i].start, tbl[i].tgt, lat, d, e, nce, ninc, nvlow, after, tmo);
      nm = $sformatf("vec%0d", i);
      check({nm, "_timeout"}, tmo, 0);
      check({nm, "_done"}, d, 1);
      check({nm, "_err"}, e, 0);
      check({nm, "_lat"}, lat, tbl[i].exp_lat);
      check({nm, "_ce"}, nce, tbl[i].exp_ce);
      check({nm, "_inc"}, ninc, tbl[i].exp_inc);
      check({nm, "_vtc_low"}, nvlow, tbl[i].exp_vlow);
      check({nm, "_tap"}, tap, tbl[i].exp_tap);
      check({nm, "_pulse_1cyc"}, after, 0);
    end
`else
    run_req(0, 300, lat, d, e, nce, ninc, nvlow, after, tmo);
    check("load_timeout", tmo, 0);
    check("load_done", d, 1);
    check("load_lat", lat, 13);
    check("load_pulses", load_cnt, 1);
    check("load_cntin", last_cntin, 300);
    check("load_ce", nce, 1);
    check("load_inc", ninc, 0);
    check("load_tap", tap, 300);
`endif

    // Frozen element: step budget exhausted, ERR instead of DONE
    frozen = 1'b1;
    run_req(5, 9, lat, d, e, nce, ninc, nvlow, after, tmo);
    predict(5, 9, 1, pn, plat, pd, pe, pfin, pinc, pvlow);
    check("frz_timeout", tmo, 0);
    check("frz_ce", nce, 511);
    check("frz_err", e, 1);
    check("frz_done", d, 0);
    check("frz_lat", lat, plat);
    check("frz_en_vtc", DLY_EN_VTC, 1);
    check("frz_ready", REQ_READY, 1);
    frozen = 1'b0;

    // Reset during the second SETTLE of a 0->3 request
    preset(0);
    REQ_VALID = 1'b1; REQ_TAP = 9'd3;
    @(negedge CLK); a = cyc; REQ_VALID = 1'b0;
    repeat (9) @(negedge CLK);
    check("mid_busy", BUSY, 1);
    check("mid_en_vtc", DLY_EN_VTC, 0);
    dc0 = done_cnt; ec0 = err_cnt;
    RST = 1'b1;
    @(negedge CLK);
    check("mrst_en_vtc", DLY_EN_VTC, 1);
    check("mrst_busy", BUSY, 0);
    check("mrst_ce", DLY_CE, 0);
    RST = 1'b0;
    repeat (30) @(negedge CLK);
    check("mrst_no_done", done_cnt - dc0, 0);
    check("mrst_no_err", err_cnt - ec0, 0);
    check("mrst_tap_kept", tap, 2);
    check("mrst_ready", REQ_READY, 1);
    run_req(0, 1, lat, d, e, nce, ninc, nvlow, after, tmo);
    predict(0, 1, 0, pn, plat, pd, pe, pfin, pinc, pvlow);
    check("post_rst_done", d, 1);
    check("post_rst_lat", lat, plat);
    check("post_rst_tap", tap, 1);

    // Random requests against the reference
    for (int i = 0; i < 10; i++) begin
      int s, t;
      s = int'($urandom_range(0, 511));
      t = s + int'($urandom_range(0, 16)) - 8;
      if (t < 0) t = 0;
      if (t > 511) t = 511;
      predict(s, t, 0, pn, plat, pd, pe, pfin, pinc, pvlow);
      run_req(s, t, lat, d, e, nce, ninc, nvlow, after, tmo);
      nm = $sformatf("rnd%0d_%0d_to_%0d", i, s, t);
      check({nm, "_timeout"}, tmo, 0);
      check({nm, "_done"}, d, pd);
      check({nm, "_err"}, e, pe);
      check({nm, "_lat"}, lat, plat);
      check({nm, "_ce"}, nce, pn);
      check({nm, "_inc"}, ninc, pinc);
      check({nm, "_vtc_low"}, nvlow, pvlow);
      check({nm, "_tap"}, tap, pfin);
    end

    check("ce_back_to_back", viol_ce, 0);
    check("ce_with_en_vtc", viol_vtc, 0);
    check("done_and_err", viol_de, 0);
`ifndef DLY_TAP_LOAD_MODE_EN
    check("load_never", load_cnt, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/delay_tap_ctrl.md
DELAY_TAP_CTRL -- requirements
Module: delay_tap_ctrl

Interface
REQ-001 Parameters SHALL be as follows:
- VTC_WAIT, default 8: cycles EN_VTC is held low before the first adjustment, and cycles it is held high after the last adjustment (range 1..255).
- SETTLE_CYCLES, default 2: wait cycles between a tap command and the CNTVALUEOUT check (range 0..15).
- MAX_STEPS, default 511: step commands allowed per request before ERR.

REQ-002 Ports SHALL be as follows (name, direction, width, meaning); reset is synchronous, active-high:
- CLK, in, 1: the single clock; all logic on its rising edge.
- RST, in, 1: synchronous active-high reset.
- REQ_VALID, in, 1: tap request valid.
- REQ_TAP, in, 9: target tap.
- REQ_READY, out, 1: controller can accept a request.
- BUSY, out, 1: a request is in progress.
- DONE, out, 1: one-cycle pulse, target reached.
- ERR, out, 1: one-cycle pulse, target not reached.
- DLY_CE, out, 1: delay element CE.
- DLY_INC, out, 1: delay element INC.
- DLY_LOAD, out, 1: delay element LOAD.
- DLY_CNTVALUEIN, out, 9: delay element CNTVALUEIN.
- DLY_EN_VTC, out, 1: delay element EN_VTC.
- DLY_CNTVALUEOUT, in, 9: delay element current tap.

Function
REQ-003 All outputs SHALL be registered.
REQ-004 The FSM states SHALL be IDLE, VTC_OFF, STEP, SETTLE, CHECK and VTC_ON.
REQ-005 REQ_READY SHALL be 1 only in IDLE; a request is accepted on a rising edge with REQ_VALID & REQ_READY, capturing REQ_TAP as target.
REQ-006 REQ_VALID outside IDLE SHALL be ignored; there is no queuing.
REQ-007 On acceptance with REQ_TAP == DLY_CNTVALUEOUT, the block SHALL stay in IDLE, pulse DONE the next cycle, and issue no DLY_CE or EN_VTC change.
REQ-008 Otherwise the block SHALL enter VTC_OFF, drive DLY_EN_VTC=0 and BUSY=1, and remain in VTC_OFF for VTC_WAIT cycles.
REQ-009 In STEP (1 cycle) the block SHALL drive DLY_CE=1 and DLY_INC = (target > DLY_CNTVALUEOUT), increment the step counter, then go to SETTLE.
REQ-010 SETTLE SHALL last SETTLE_CYCLES cycles (0 skips it) and then go to CHECK.
REQ-011 CHECK (1 cycle) SHALL select the next state:
- DLY_CNTVALUEOUT == target: go to VTC_ON with result OK.
- Else, step counter == MAX_STEPS: go to VTC_ON with result FAIL.
- Else: go to STEP.
REQ-012 Direction SHALL be re-evaluated every STEP, so an overshoot is corrected rather than wrapped; the controller never relies on 511<->0 wrap.
REQ-013 VTC_ON SHALL drive DLY_EN_VTC=1 for VTC_WAIT cycles, then return to IDLE, pulsing DONE (OK) or ERR (FAIL) in the first IDLE cycle and deasserting BUSY.
REQ-014 DONE and ERR SHALL never be high together, and each SHALL be high for exactly one cycle per request.
REQ-015 Latency from acceptance to DONE/ERR SHALL be VTC_WAIT + n*(SETTLE_CYCLES+2) + VTC_WAIT + 1 cycles, where n is the number of STEP visits.
REQ-016 DLY_CE SHALL never be high in two consecutive cycles.
REQ-017 DLY_EN_VTC SHALL be 0 whenever DLY_CE is 1.

Reset
REQ-018 While RST=1 at a rising edge, next-cycle outputs SHALL be:
- State IDLE; REQ_READY=1 from the first cycle after RST falls (0 while in reset).
- BUSY=0, DONE=0, ERR=0.
- DLY_CE=0, DLY_INC=0, DLY_LOAD=0, DLY_CNTVALUEIN=0.
- DLY_EN_VTC=1.
- Step counter 0.
REQ-019 Reset mid-request SHALL abandon the request without DONE/ERR and restore DLY_EN_VTC=1 immediately; the element keeps its intermediate tap.

Configuration
REQ-020 With macro DLY_TAP_LOAD_MODE_EN defined, the first STEP of a request SHALL instead drive DLY_CE=1, DLY_LOAD=1 and DLY_CNTVALUEIN=target for one cycle, then follow SETTLE/CHECK.
- If that CHECK fails, subsequent visits SHALL use incremental stepping per REQ-009.
- The load counts as one step.
REQ-021 Without DLY_TAP_LOAD_MODE_EN, DLY_LOAD and DLY_CNTVALUEIN SHALL be held 0 and only incremental stepping is used.

Verification (VTC_WAIT=4, SETTLE_CYCLES=2, bench model of a VAR_LOAD delay element updating CNTVALUEOUT one cycle after CE)
REQ-022 Tap 0, request 3 -> three DLY_CE pulses with INC=1, DLY_EN_VTC low throughout, DONE 21 cycles after acceptance, final tap 3.
REQ-023 Tap 10, request 7 -> three DLY_CE pulses with INC=0, DONE at cycle 21, final tap 7.
REQ-024 Tap 100, request 100 -> DONE the next cycle, DLY_EN_VTC never low, no DLY_CE.
REQ-025 Model CNTVALUEOUT frozen at 5, request 9 -> exactly 511 DLY_CE pulses, ERR (no DONE), then DLY_EN_VTC=1 and REQ_READY=1.
REQ-026 RST asserted during the second SETTLE of a 0->3 request -> next cycle DLY_EN_VTC=1, BUSY=0, DLY_CE=0, no DONE/ERR; a new request 0->1 then completes normally.
REQ-027 With DLY_TAP_LOAD_MODE_EN, tap 0, request 300 -> one cycle with CE=LOAD=1 and CNTVALUEIN=300, DONE 13 cycles after acceptance, no INC pulses.
